// File: rtl/traffic_ctrl_fsm.sv
// Two-road (NS/EW) intersection controller: 1 s prescaler, green/yellow/all-red phase
// sequencing, pedestrian-shortened greens, flashing-yellow night mode and a seconds countdown.
module traffic_ctrl_fsm #(
  parameter int unsigned TIME_1S  = 50000000,
  parameter int unsigned T_GREEN  = 15,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_PED    = 5,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             night_mode,
  input  logic             ped_req,
  output logic [2:0]       led_ns,
  output logic [2:0]       led_ew,
  output logic [CNT_W-1:0] countdown,
  output logic [2:0]       phase
);

  localparam int unsigned PW = $clog2(TIME_1S);

  localparam logic [PW-1:0]    PRESC_MAX  = PW'(TIME_1S - 1);
  localparam logic [CNT_W-1:0] REM_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] REM_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] REM_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] REM_PED    = CNT_W'(T_PED - 1);

  localparam logic [2:0] LAMP_G   = 3'b110;
  localparam logic [2:0] LAMP_Y   = 3'b101;
  localparam logic [2:0] LAMP_R   = 3'b011;
  localparam logic [2:0] LAMP_OFF = 3'b111;

  typedef enum logic [2:0] {
    StNsG   = 3'd0,
    StNsY   = 3'd1,
    StAr1   = 3'd2,
    StEwG   = 3'd3,
    StEwY   = 3'd4,
    StAr2   = 3'd5,
    StNight = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             blink_q, blink_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_green_q, ped_green_d;

  logic tick;
  logic is_green;
  logic ped_now;
  logic ped_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StNsG;
      presc_q     <= '0;
      rem_q       <= REM_GREEN;
      blink_q     <= 1'b1;
      ped_pend_q  <= 1'b0;
      ped_green_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      rem_q       <= rem_d;
      blink_q     <= blink_d;
      ped_pend_q  <= ped_pend_d;
      ped_green_q <= ped_green_d;
    end
  end

  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    presc_d  = tick ? '0 : presc_q + PW'(1);
    is_green = (state_q == StNsG) || (state_q == StEwG);
    // A request arriving on the tick cycle itself already counts for that tick.
    ped_now  = ped_pend_q | ped_req;

    state_d = state_q;
    rem_d   = rem_q;
    blink_d = blink_q;

    if (tick) begin
      case (state_q)
        StNsG, StEwG: begin
          if (rem_q == '0) begin
            state_d = (state_q == StNsG) ? StNsY : StEwY;
            rem_d   = REM_YELLOW;
          end else if (ped_now && (rem_q > REM_PED)) begin
            rem_d = REM_PED;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
        StNsY, StEwY: begin
          if (rem_q == '0) begin
            if (night_mode) begin
              state_d = StNight;
              rem_d   = '0;
              blink_d = 1'b1;
            end else begin
              state_d = (state_q == StNsY) ? StAr1 : StAr2;
              rem_d   = REM_ALLRED;
            end
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
        StAr1, StAr2: begin
          if (rem_q == '0) begin
            state_d = (state_q == StAr1) ? StEwG : StNsG;
            rem_d   = REM_GREEN;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
        StNight: begin
          blink_d = ~blink_q;
          if (!night_mode) begin
            state_d = StAr2;
            rem_d   = REM_ALLRED;
          end
        end
        default: begin
          state_d = StNsG;
          rem_d   = REM_GREEN;
        end
      endcase
    end

    // A pending request is retired only once some green has been served while it was pending.
    ped_clr = (state_d != state_q) && ped_green_q &&
              ((state_d == StAr1) || (state_d == StAr2) || (state_d == StNight));
    ped_green_d = ped_clr ? 1'b0 : (ped_green_q | (is_green & ped_now));
    ped_pend_d  = (ped_clr ? 1'b0 : ped_pend_q) | (ped_req & (state_q != StNight));
  end

  always_comb begin
    led_ns = LAMP_R;
    led_ew = LAMP_R;
    case (state_q)
      StNsG:   led_ns = LAMP_G;
      StNsY:   led_ns = LAMP_Y;
      StEwG:   led_ew = LAMP_G;
      StEwY:   led_ew = LAMP_Y;
      StNight: begin
        led_ns = blink_q ? LAMP_Y : LAMP_OFF;
        led_ew = blink_q ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
    countdown = (state_q == StNight) ? '0 : rem_q + CNT_W'(1);
    phase     = state_q;
  end

endmodule

// File: tb/tb_traffic_ctrl_fsm.sv
// Self-checking bench for traffic_ctrl_fsm: directed scenarios plus random ped/night stimulus,
// compared every cycle against a seconds-level behavioural model of the intersection.
module tb_traffic_ctrl_fsm;

  localparam int TIME_1S  = 4;
  localparam int T_GREEN  = 6;
  localparam int T_YELLOW = 2;
  localparam int T_ALLRED = 1;
  localparam int T_PED    = 2;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             night_mode = 1'b0;
  logic             ped_req = 1'b0;
  logic [2:0]       led_ns;
  logic [2:0]       led_ew;
  logic [CNT_W-1:0] countdown;
  logic [2:0]       phase;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  traffic_ctrl_fsm #(
    .TIME_1S  (TIME_1S),
    .T_GREEN  (T_GREEN),
    .T_YELLOW (T_YELLOW),
    .T_ALLRED (T_ALLRED),
    .T_PED    (T_PED),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .night_mode (night_mode),
    .ped_req    (ped_req),
    .led_ns     (led_ns),
    .led_ew     (led_ew),
    .countdown  (countdown),
    .phase      (phase)
  );

  // Model: phase number, whole seconds left, cycle within the current second.
  int dur[6] = '{T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED};
  int m_phase, m_left, m_cyc;
  bit m_pend, m_seen, m_blink;

  task automatic m_reset();
    m_phase = 0;
    m_left  = T_GREEN;
    m_cyc   = 0;
    m_pend  = 0;
    m_seen  = 0;
    m_blink = 1;
  endtask

  task automatic m_clock(input bit night, input bit ped);
    bit tick;
    bit green;
    int nxt;
    tick  = (m_cyc == TIME_1S - 1);
    green = (m_phase == 0) || (m_phase == 3);
    nxt   = m_phase;
    m_cyc = (m_cyc + 1) % TIME_1S;
    if (tick) begin
      if (m_phase == 6) begin
        m_blink = !m_blink;
        if (!night) begin
          nxt    = 5;
          m_left = T_ALLRED;
        end
      end else if (m_left == 1) begin
        if ((m_phase == 1 || m_phase == 4) && night) begin
          nxt     = 6;
          m_blink = 1;
        end else begin
          nxt    = (m_phase + 1) % 6;
          m_left = dur[nxt];
        end
      end else if (green && (m_pend || ped) && m_left > T_PED) begin
        m_left = T_PED;
      end else begin
        m_left = m_left - 1;
      end
    end
    if (nxt != m_phase && (nxt == 2 || nxt == 5 || nxt == 6) && m_seen) begin
      m_pend = 0;
      m_seen = 0;
    end else if (green && (m_pend || ped)) begin
      m_seen = 1;
    end
    if (ped && m_phase != 6) m_pend = 1;
    m_phase = nxt;
  endtask

  function automatic logic [5:0] m_lamps();
    case (m_phase)
      0:       return {3'b110, 3'b011};
      1:       return {3'b101, 3'b011};
      3:       return {3'b011, 3'b110};
      4:       return {3'b011, 3'b101};
      6:       return m_blink ? {3'b101, 3'b101} : {3'b111, 3'b111};
      default: return {3'b011, 3'b011};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [5:0] lamps;
    lamps = m_lamps();
    chk("phase", 32'(phase), 32'(m_phase));
    chk("countdown", 32'(countdown), (m_phase == 6) ? 32'd0 : 32'(m_left));
    chk("led_ns", 32'(led_ns), 32'(lamps[5:3]));
    chk("led_ew", 32'(led_ew), 32'(lamps[2:0]));
    chk("dual_green", 32'(led_ns == 3'b110 && led_ew == 3'b110), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    m_clock(night_mode, ped_req);
    #1;
    check_all();
  endtask

  task automatic wait_phase(input int target, input int budget);
    int n;
    n = 0;
    while (m_phase != target && n < budget) begin
      step();
      n++;
    end
    chk("wait_phase", 32'(phase), 32'(target));
  endtask

  initial begin
    int n;
    // Power-on reset.
    m_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Free run: full 18-tick cycle back to NS_G entry.
    repeat (71) step();
    chk("cycle_back_phase", 32'(phase), 32'd0);
    chk("cycle_back_cd", 32'(countdown), 32'd6);

    // Ped pulse at start of NS_G shortens it to T_PED at the next tick.
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    n = 0;
    while (m_left == T_GREEN && n < 8) begin
      step();
      n++;
    end
    chk("ped_short_cd", 32'(countdown), 32'd2);

    // Ped during NS_Y applies to EW_G.
    wait_phase(1, 40);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_phase(3, 40);
    wait_phase(0, 80);

    // Night mode entered from NS_G: green and yellow complete first.
    step();
    night_mode = 1'b1;
    wait_phase(6, 80);
    repeat (12) step();
    night_mode = 1'b0;
    wait_phase(5, 20);
    wait_phase(0, 20);

    // Random ped requests and night toggling.
    for (int i = 0; i < 800; i++) begin
      ped_req = ($urandom_range(0, 19) == 0);
      if (i % 50 == 0) night_mode = ($urandom_range(0, 3) == 0);
      step();
    end
    ped_req    = 1'b0;
    night_mode = 1'b0;

    // Reset mid EW_G with a pending request.
    wait_phase(3, 200);
    step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    rst_n   = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    // Pending request must be gone: NS_G runs its full length.
    repeat (80) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
